// File: rtl/udma_eth_frame_pkg.sv
// Register map, CFG bit positions and FSM/status encodings shared by the
// uDMA Ethernet frame config sequencer and its poll timer.
package udma_eth_frame_pkg;

   localparam int unsigned CFG_AW = 5;
   localparam int unsigned CFG_DW = 32;

   localparam logic [CFG_AW-1:0] CH_RX_BASE = 5'h00;
   localparam logic [CFG_AW-1:0] CH_TX_BASE = 5'h04;
   localparam logic [CFG_AW-1:0] REG_SADDR  = 5'h00;
   localparam logic [CFG_AW-1:0] REG_SIZE   = 5'h01;
   localparam logic [CFG_AW-1:0] REG_CFG    = 5'h02;

   localparam int unsigned CFG_CONT_BIT = 0;
   localparam int unsigned CFG_EN_BIT   = 4;
   localparam int unsigned CFG_PEND_BIT = 5;
   localparam int unsigned CFG_CLR_BIT  = 6;

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_SADDR, ST_WR_SIZE, ST_WR_CFG,
      ST_POLL_GAP, ST_POLL_RD, ST_WR_CLR, ST_DONE
   } state_e;

   typedef enum logic [1:0] {
      STAT_OK      = 2'b00,
      STAT_ABORT   = 2'b01,
      STAT_TIMEOUT = 2'b10
   } status_e;

   typedef struct packed {
      logic              valid;
      logic              rwn;
      logic [CFG_AW-1:0] addr;
      logic [CFG_DW-1:0] data;
   } cfg_req_t;

   // Config bus request issued on entry to a given state; all-zero for non-bus states.
   function automatic cfg_req_t cfg_for(input state_e st, input logic dir,
                                        input logic [CFG_DW-1:0] saddr,
                                        input logic [CFG_DW-1:0] size,
                                        input logic cont);
      cfg_req_t          r;
      logic [CFG_AW-1:0] base;
      base = dir ? CH_TX_BASE : CH_RX_BASE;
      r    = '0;
      case (st)
         ST_WR_SADDR: begin
            r.valid = 1'b1;
            r.addr  = base + REG_SADDR;
            r.data  = saddr;
         end
         ST_WR_SIZE: begin
            r.valid = 1'b1;
            r.addr  = base + REG_SIZE;
            r.data  = size;
         end
         ST_WR_CFG: begin
            r.valid              = 1'b1;
            r.addr               = base + REG_CFG;
            r.data[CFG_EN_BIT]   = 1'b1;
            r.data[CFG_CONT_BIT] = cont;
         end
         ST_POLL_RD: begin
            r.valid = 1'b1;
            r.rwn   = 1'b1;
            r.addr  = base + REG_CFG;
         end
         ST_WR_CLR: begin
            r.valid             = 1'b1;
            r.addr              = base + REG_CFG;
            r.data[CFG_CLR_BIT] = 1'b1;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/udma_eth_frame_poll_timer.sv
// Idle-gap counter between status polls and poll-attempt counter for timeout.
module udma_eth_frame_poll_timer #(
   parameter int unsigned POLL_GAP  = 8,
   parameter int unsigned MAX_POLLS = 1024
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic gap_load,
   input  logic gap_tick,
   input  logic poll_clr,
   input  logic poll_tick,
   output logic gap_exp_c,
   output logic poll_exp_c
);

   localparam int unsigned GAP_W  = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int unsigned POLL_W = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

   logic [GAP_W-1:0]  gap_cnt_q;
   logic [POLL_W-1:0] poll_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gap_cnt_q  <= '0;
         poll_cnt_q <= '0;
      end else begin
         if (gap_load)      gap_cnt_q <= '0;
         else if (gap_tick) gap_cnt_q <= gap_cnt_q + GAP_W'(1);
         if (poll_clr)       poll_cnt_q <= '0;
         else if (poll_tick) poll_cnt_q <= poll_cnt_q + POLL_W'(1);
      end
   end

   // Expiry fires in the last counted cycle so the FSM can move on at that edge.
   assign gap_exp_c  = (gap_cnt_q == GAP_W'(POLL_GAP - 1));
   assign poll_exp_c = (poll_cnt_q == POLL_W'(MAX_POLLS - 1));

endmodule

// File: rtl/udma_eth_frame_cfg_seq.sv
// Programs a uDMA Ethernet channel (SADDR, SIZE, CFG) over the config bus,
// then polls CFG until the channel goes idle, with abort and poll timeout.
module udma_eth_frame_cfg_seq
   import udma_eth_frame_pkg::*;
#(
   parameter int unsigned L2_AWIDTH_NOAL = 12,
   parameter int unsigned TRANS_SIZE     = 16,
   parameter int unsigned POLL_GAP       = 8,
   parameter int unsigned MAX_POLLS      = 1024
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_dir_i,
   input  logic [L2_AWIDTH_NOAL-1:0] cmd_addr_i,
   input  logic [TRANS_SIZE-1:0]     cmd_size_i,
   input  logic                      cmd_cont_i,
   input  logic                      abort_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [1:0]                status_o,
   output logic [31:0]               cfg_data_o,
   output logic [4:0]                cfg_addr_o,
   output logic                      cfg_valid_o,
   output logic                      cfg_rwn_o,
   input  logic [31:0]               cfg_data_i,
   input  logic                      cfg_ready_i
);

   state_e                state_q;
   status_e               status_q;
   cfg_req_t              cfg_q;
   logic                  busy_q, ready_q, done_q, abort_q;
   logic                  dir_q, cont_q;
   logic [TRANS_SIZE-1:0] size_q;

   logic     xfer_c, rd_busy_c, abort_arm_c, abort_any_c;
   logic     gap_load_c, gap_tick_c, poll_clr_c, poll_tick_c;
   logic     gap_exp_c, poll_exp_c;
   cfg_req_t clr_req_c;
   logic     unused_c;

   assign xfer_c      = cfg_q.valid & cfg_ready_i;
   assign rd_busy_c   = cfg_data_i[CFG_EN_BIT] | cfg_data_i[CFG_PEND_BIT];
   assign abort_arm_c = state_q inside {ST_WR_SADDR, ST_WR_SIZE, ST_WR_CFG, ST_POLL_GAP, ST_POLL_RD};
   assign abort_any_c = abort_arm_c & (abort_q | abort_i);
   assign gap_load_c  = xfer_c & ((state_q == ST_WR_CFG) | (state_q == ST_POLL_RD));
   assign gap_tick_c  = (state_q == ST_POLL_GAP);
   assign poll_clr_c  = (state_q == ST_IDLE);
   assign poll_tick_c = xfer_c & rd_busy_c & (state_q == ST_POLL_RD);
   assign clr_req_c   = cfg_for(ST_WR_CLR, dir_q, '0, '0, 1'b0);
   assign unused_c    = ^{cfg_data_i[31:6], cfg_data_i[3:0]};

   udma_eth_frame_poll_timer #(
      .POLL_GAP  (POLL_GAP),
      .MAX_POLLS (MAX_POLLS)
   ) u_poll_timer (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .gap_load   (gap_load_c),
      .gap_tick   (gap_tick_c),
      .poll_clr   (poll_clr_c),
      .poll_tick  (poll_tick_c),
      .gap_exp_c  (gap_exp_c),
      .poll_exp_c (poll_exp_c)
   );

   // Bus requests are registered together with the state they belong to, so a
   // request is only ever replaced at its own completion edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         status_q <= STAT_OK;
         cfg_q    <= '0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
         dir_q    <= 1'b0;
         cont_q   <= 1'b0;
         size_q   <= '0;
      end else begin
         done_q <= 1'b0;
         if (abort_arm_c && abort_i) abort_q <= 1'b1;
         case (state_q)
            ST_IDLE: if (cmd_valid_i) begin
               dir_q    <= cmd_dir_i;
               cont_q   <= cmd_cont_i;
               size_q   <= cmd_size_i;
               abort_q  <= 1'b0;
               status_q <= STAT_OK;
               busy_q   <= 1'b1;
               ready_q  <= 1'b0;
               state_q  <= ST_WR_SADDR;
               cfg_q    <= cfg_for(ST_WR_SADDR, cmd_dir_i, CFG_DW'(cmd_addr_i), '0, 1'b0);
            end
            ST_WR_SADDR: if (xfer_c) begin
               if (abort_any_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_ABORT;
                  cfg_q    <= clr_req_c;
               end else begin
                  state_q <= ST_WR_SIZE;
                  cfg_q   <= cfg_for(ST_WR_SIZE, dir_q, '0, CFG_DW'(size_q), 1'b0);
               end
            end
            ST_WR_SIZE: if (xfer_c) begin
               if (abort_any_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_ABORT;
                  cfg_q    <= clr_req_c;
               end else begin
                  state_q <= ST_WR_CFG;
                  cfg_q   <= cfg_for(ST_WR_CFG, dir_q, '0, '0, cont_q);
               end
            end
            ST_WR_CFG: if (xfer_c) begin
               if (abort_any_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_ABORT;
                  cfg_q    <= clr_req_c;
               end else if (cont_q) begin
                  state_q  <= ST_DONE;
                  status_q <= STAT_OK;
                  done_q   <= 1'b1;
                  cfg_q    <= '0;
               end else begin
                  state_q <= ST_POLL_GAP;
                  cfg_q   <= '0;
               end
            end
            ST_POLL_GAP: begin
               if (abort_any_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_ABORT;
                  cfg_q    <= clr_req_c;
               end else if (gap_exp_c) begin
                  state_q <= ST_POLL_RD;
                  cfg_q   <= cfg_for(ST_POLL_RD, dir_q, '0, '0, 1'b0);
               end
            end
            // An idle channel on the final read takes priority over a concurrent abort.
            ST_POLL_RD: if (xfer_c) begin
               if (!rd_busy_c) begin
                  state_q  <= ST_DONE;
                  status_q <= STAT_OK;
                  done_q   <= 1'b1;
                  cfg_q    <= '0;
               end else if (abort_any_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_ABORT;
                  cfg_q    <= clr_req_c;
               end else if (poll_exp_c) begin
                  state_q  <= ST_WR_CLR;
                  status_q <= STAT_TIMEOUT;
                  cfg_q    <= clr_req_c;
               end else begin
                  state_q <= ST_POLL_GAP;
                  cfg_q   <= '0;
               end
            end
            ST_WR_CLR: if (xfer_c) begin
               state_q <= ST_DONE;
               done_q  <= 1'b1;
               cfg_q   <= '0;
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign status_o    = status_q;
   assign cfg_valid_o = cfg_q.valid;
   assign cfg_rwn_o   = cfg_q.rwn;
   assign cfg_addr_o  = cfg_q.addr;
   assign cfg_data_o  = cfg_q.data;

endmodule

// File: tb/tb_udma_eth_frame_cfg_seq.sv
// Self-checking bench: config-bus slave model with scoreboard of expected
// transactions, a vector table of commands, and abort/reset corner sequences.
`timescale 1ns/1ps
module tb_udma_eth_frame_cfg_seq;

   localparam int unsigned GAP  = 4;
   localparam int unsigned MAXP = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_dir, cmd_cont, abort;
   logic [11:0] cmd_addr;
   logic [15:0] cmd_size;
   logic        busy, done;
   logic [1:0]  status;
   logic [31:0] cfg_data_out, cfg_data_in;
   logic [4:0]  cfg_addr;
   logic        cfg_valid, cfg_rwn, cfg_ready;

   always #5 clk = ~clk;

   udma_eth_frame_cfg_seq #(
      .L2_AWIDTH_NOAL (12),
      .TRANS_SIZE     (16),
      .POLL_GAP       (GAP),
      .MAX_POLLS      (MAXP)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_dir_i   (cmd_dir),
      .cmd_addr_i  (cmd_addr),
      .cmd_size_i  (cmd_size),
      .cmd_cont_i  (cmd_cont),
      .abort_i     (abort),
      .busy_o      (busy),
      .done_o      (done),
      .status_o    (status),
      .cfg_data_o  (cfg_data_out),
      .cfg_addr_o  (cfg_addr),
      .cfg_valid_o (cfg_valid),
      .cfg_rwn_o   (cfg_rwn),
      .cfg_data_i  (cfg_data_in),
      .cfg_ready_i (cfg_ready)
   );

   typedef struct {
      logic [4:0]  addr;
      logic        rwn;
      logic [31:0] data;
      logic        gap_chk;
   } txn_t;

   typedef struct {
      logic        dir;
      logic [11:0] addr;
      logic [15:0] size;
      logic        cont;
      int          delay;
      int          busy_polls;
      logic [31:0] busy_val;
      logic [31:0] idle_val;
      logic [1:0]  exp_st;
   } vec_t;

   txn_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Slave model knobs
   int          delay     = 0;
   int          busy_left = 0;
   logic [31:0] busy_val  = 32'h30;
   logic [31:0] idle_val  = 32'h0;
   int          n_rd      = 0;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void push(input logic [4:0] a, input logic r, input logic [31:0] d, input logic g);
      txn_t t;
      t.addr = a; t.rwn = r; t.data = d; t.gap_chk = g;
      exp_q.push_back(t);
   endfunction

   // Expected bus traffic for one command whose channel reports busy for busy_polls reads.
   function automatic void push_cmd(input logic dir, input logic [11:0] addr, input logic [15:0] size,
                                    input logic cont, input int busy_polls);
      logic [4:0] base;
      int         nrd;
      base = dir ? 5'h04 : 5'h00;
      push(base, 1'b0, 32'(addr), 1'b0);
      push(base + 5'd1, 1'b0, 32'(size), 1'b0);
      push(base + 5'd2, 1'b0, 32'h10 | 32'(cont), 1'b0);
      if (!cont) begin
         nrd = (busy_polls >= int'(MAXP)) ? int'(MAXP) : busy_polls + 1;
         for (int k = 0; k < nrd; k++) push(base + 5'd2, 1'b1, 32'h0, 1'b1);
         if (busy_polls >= int'(MAXP)) push(base + 5'd2, 1'b0, 32'h40, 1'b0);
      end
   endfunction

   // Config-bus slave: ready after 'delay' wait cycles, hold/gap checks, scoreboard pop.
   logic        prev_valid = 1'b0, prev_done = 1'b0;
   int          wait_cnt = 0, gap_run = 0, start_gap = 0;
   logic [4:0]  hold_addr;
   logic        hold_rwn;
   logic [31:0] hold_data;
   txn_t        e;

   always @(negedge clk) begin
      if (rst) begin
         cfg_ready   = 1'b0;
         cfg_data_in = 32'h0;
         prev_valid  = 1'b0;
         prev_done   = 1'b0;
         wait_cnt    = 0;
      end else begin
         if (!cfg_valid || cfg_rwn) check("data_zero", cfg_data_out, 32'h0);
         if (cfg_valid) begin
            if (!prev_valid || prev_done) begin
               wait_cnt  = 0;
               start_gap = gap_run;
               hold_addr = cfg_addr;
               hold_rwn  = cfg_rwn;
               hold_data = cfg_data_out;
            end else begin
               wait_cnt++;
               check("hold_addr", 32'(cfg_addr), 32'(hold_addr));
               check("hold_rwn", 32'(cfg_rwn), 32'(hold_rwn));
               check("hold_data", cfg_data_out, hold_data);
            end
            cfg_ready   = (wait_cnt >= delay);
            cfg_data_in = (busy_left > 0) ? busy_val : idle_val;
            if (cfg_ready) begin
               if (exp_q.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL sb_extra: got addr=0x%0h rwn=%0b data=0x%0h, expected no transaction",
                           cfg_addr, cfg_rwn, cfg_data_out);
               end else begin
                  e = exp_q.pop_front();
                  check("sb_addr", 32'(cfg_addr), 32'(e.addr));
                  check("sb_rwn", 32'(cfg_rwn), 32'(e.rwn));
                  check("sb_data", cfg_data_out, e.data);
                  if (e.gap_chk) check("sb_gap", 32'(start_gap), 32'(GAP));
               end
               if (cfg_rwn) begin
                  n_rd++;
                  if (busy_left > 0) busy_left--;
               end
               prev_done = 1'b1;
               gap_run   = 0;
            end else begin
               prev_done = 1'b0;
            end
         end else begin
            cfg_ready = 1'b0;
            prev_done = 1'b0;
            gap_run++;
         end
         prev_valid = cfg_valid;
      end
   end

   task automatic start_cmd(input logic dir, input logic [11:0] addr, input logic [15:0] size, input logic cont);
      int cyc = 0;
      while (!cmd_ready && cyc < 200) begin @(negedge clk); cyc++; end
      check("cmd_ready", 32'(cmd_ready), 32'h1);
      cmd_valid = 1'b1; cmd_dir = dir; cmd_addr = addr; cmd_size = size; cmd_cont = cont;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input logic [1:0] exp_st, input string tag);
      int         cyc = 0;
      logic [1:0] st;
      while (!done && cyc < 2000) begin @(negedge clk); cyc++; end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s_timeout: done_o low after %0d cycles, expected a done pulse", tag, cyc);
      end
      st = status;
      check({tag, "_status"}, 32'(st), 32'(exp_st));
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'h0);
      check({tag, "_idle_busy"}, 32'(busy), 32'h0);
      check({tag, "_idle_ready"}, 32'(cmd_ready), 32'h1);
      check({tag, "_status_hold"}, 32'(status), 32'(exp_st));
      check({tag, "_sb_left"}, 32'(exp_q.size()), 32'h0);
      exp_q.delete();
   endtask

   vec_t vecs[6];

   initial begin
      int cyc;
      int n0;
      rst = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_size = '0;
      cmd_cont = 1'b0; abort = 1'b0;

      vecs[0] = '{1'b0, 12'h123, 16'h0040, 1'b0, 0, 0,    32'h30, 32'h0,        2'b00};
      vecs[1] = '{1'b1, 12'h456, 16'h0080, 1'b1, 3, 0,    32'h30, 32'h0,        2'b00};
      vecs[2] = '{1'b0, 12'hABC, 16'h0010, 1'b0, 0, 1000, 32'h30, 32'h0,        2'b10};
      vecs[3] = '{1'b1, 12'hFFF, 16'hFFFF, 1'b0, 1, 2,    32'h10, 32'hFFFFFF8F, 2'b00};
      vecs[4] = '{1'b0, 12'h000, 16'h0000, 1'b1, 2, 0,    32'h30, 32'h0,        2'b00};
      vecs[5] = '{1'b1, 12'h800, 16'h0001, 1'b0, 2, 3,    32'h20, 32'h01,       2'b00};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 32'(cfg_valid), 32'h0);
      check("rst_rwn", 32'(cfg_rwn), 32'h0);
      check("rst_addr", 32'(cfg_addr), 32'h0);
      check("rst_data", cfg_data_out, 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_status", 32'(status), 32'h0);
      check("rst_ready", 32'(cmd_ready), 32'h1);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         delay = vecs[i].delay; busy_left = vecs[i].busy_polls;
         busy_val = vecs[i].busy_val; idle_val = vecs[i].idle_val;
         push_cmd(vecs[i].dir, vecs[i].addr, vecs[i].size, vecs[i].cont, vecs[i].busy_polls);
         start_cmd(vecs[i].dir, vecs[i].addr, vecs[i].size, vecs[i].cont);
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'h1);
         wait_done(vecs[i].exp_st, $sformatf("vec%0d", i));
      end

      // Abort while WR_SIZE is stalled: SIZE completes, then clear write, no CFG/polls
      delay = 5; busy_left = 0; idle_val = 32'h0;
      push(5'h00, 1'b0, 32'h5A5, 1'b0);
      push(5'h01, 1'b0, 32'h22, 1'b0);
      push(5'h02, 1'b0, 32'h40, 1'b0);
      start_cmd(1'b0, 12'h5A5, 16'h0022, 1'b0);
      cyc = 0;
      while (!(cfg_valid && cfg_addr == 5'h01) && cyc < 200) begin @(negedge clk); cyc++; end
      check("abort_in_size", 32'(cfg_addr), 32'h01);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done(2'b01, "abort_size");

      // Abort together with the successful final poll, held into DONE and IDLE: success wins
      delay = 2; busy_left = 1; busy_val = 32'h30; idle_val = 32'h0;
      push_cmd(1'b1, 12'h0F0, 16'h0100, 1'b0, 1);
      n0 = n_rd;
      start_cmd(1'b1, 12'h0F0, 16'h0100, 1'b0);
      cyc = 0;
      while (cyc < 300) begin
         @(negedge clk); #1;
         if (cfg_valid && cfg_rwn && cfg_ready && n_rd == n0 + 2) break;
         cyc++;
      end
      check("final_poll_seen", 32'(n_rd), 32'(n0 + 2));
      abort = 1'b1;
      @(negedge clk);
      check("final_poll_done", 32'(done), 32'h1);
      wait_done(2'b00, "abort_final");
      abort = 1'b0;

      // Reset while a poll read is outstanding
      delay = 6; busy_left = 0;
      push(5'h00, 1'b0, 32'h321, 1'b0);
      push(5'h01, 1'b0, 32'h08, 1'b0);
      push(5'h02, 1'b0, 32'h10, 1'b0);
      start_cmd(1'b0, 12'h321, 16'h0008, 1'b0);
      cyc = 0;
      while (!(cfg_valid && cfg_rwn) && cyc < 200) begin @(negedge clk); cyc++; end
      check("poll_rd_seen", 32'(cfg_rwn), 32'h1);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", 32'(cfg_valid), 32'h0);
      check("mid_rst_busy", 32'(busy), 32'h0);
      check("mid_rst_ready", 32'(cmd_ready), 32'h1);
      check("mid_rst_status", 32'(status), 32'h0);
      check("mid_rst_sb_left", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Normal command after the mid-transaction reset
      delay = 1; busy_left = 0; idle_val = 32'h0;
      push_cmd(1'b0, 12'h123, 16'h0040, 1'b0, 0);
      start_cmd(1'b0, 12'h123, 16'h0040, 1'b0);
      wait_done(2'b00, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/udma_eth_frame_cfg_seq.md
UDMA_ETH_FRAME_CFG_SEQ -- requirements
Module: udma_eth_frame_cfg_seq

Interface
REQ-001 Parameter L2_AWIDTH_NOAL, default 12: L2 start-address width.
REQ-002 Parameter TRANS_SIZE, default 16: transfer-size width.
REQ-003 Parameter POLL_GAP, default 8: idle cycles between status polls (≥1).
REQ-004 Parameter MAX_POLLS, default 1024: poll reads before timeout (≥1).
REQ-005 Clock and reset SHALL be fixed as follows: one clock; reset is synchronous and active-high.
REQ-006 Ports, in this order:
- clk_i  in  1  clock
- rst_i  in  1  reset
- cmd_valid_i  in  1  command request
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i
- cmd_dir_i  in  1  channel select: 0=RX, 1=TX
- cmd_addr_i  in  L2_AWIDTH_NOAL  start address
- cmd_size_i  in  TRANS_SIZE  size in bytes
- cmd_cont_i  in  1  continuous mode
- abort_i  in  1  abort running command
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse
- status_o  out  2  result: 00 ok, 01 aborted, 10 timeout
- cfg_data_o  out  32  config write data
- cfg_addr_o  out  5  config word address
- cfg_valid_o  out  1  config request
- cfg_rwn_o  out  1  1=read, 0=write
- cfg_data_i  in  32  config read data
- cfg_ready_i  in  1  config transaction complete

Function
REQ-007 Register map (5-bit word address): RX SADDR 0x00, SIZE 0x01, CFG 0x02; TX SADDR 0x04, SIZE 0x05, CFG 0x06 (base 0x00 RX, 0x04 TX).
REQ-008 CFG write bits: 0=continuous, 4=enable, 6=clear; CFG read bits: 0=continuous, 4=enable, 5=pending.
REQ-009 A config transaction SHALL complete in the cycle cfg_valid_o & cfg_ready_i are both high; cfg_addr_o, cfg_rwn_o and cfg_data_o SHALL be held stable while cfg_valid_o is high; read data SHALL be sampled in the completion cycle.
REQ-010 FSM states: IDLE, WR_SADDR, WR_SIZE, WR_CFG, POLL_GAP, POLL_RD, WR_CLR, DONE.
REQ-011 cmd_ready_o SHALL be high only in IDLE; on acceptance, dir/addr/size/cont SHALL be latched and the FSM SHALL enter WR_SADDR on the next cycle.
REQ-012 WR_SADDR writes the zero-extended address, WR_SIZE writes the zero-extended size, and WR_CFG writes bit4=1 and bit0=cont; each SHALL advance only on completion.
REQ-013 After WR_CFG: if cont=1, go to DONE with status 00; otherwise go to POLL_GAP.
REQ-014 POLL_GAP SHALL count exactly POLL_GAP cycles with cfg_valid_o low, then go to POLL_RD.
REQ-015 POLL_RD issues a CFG read; on completion, if bit4=0 and bit5=0, go to DONE with status 00; else increment the poll counter and go to POLL_GAP.
REQ-016 When the poll counter reaches MAX_POLLS with the channel still busy, go to WR_CLR with status 10.
REQ-017 abort_i is sampled in any busy state; the request SHALL be latched. An in-flight transaction (cfg_valid_o high) SHALL finish first and SHALL never be withdrawn. The FSM then goes to WR_CLR with status 01.
REQ-018 abort_i in IDLE or DONE SHALL be ignored. Abort in the same cycle as the successful final poll: success wins, status 00.
REQ-019 WR_CLR writes CFG with bit6=1 and all other bits 0, then goes to DONE.
REQ-020 DONE asserts done_o for exactly one cycle, then returns to IDLE; status_o SHALL hold its value until the next command is accepted.
REQ-021 busy_o SHALL be high in every state except IDLE. cfg_data_o SHALL be 0 whenever cfg_rwn_o=1 or cfg_valid_o=0.

Reset
REQ-022 With rst_i high at a clock edge: state=IDLE, cfg_valid_o=0, cfg_rwn_o=0, cfg_addr_o=0, cfg_data_o=0, done_o=0, busy_o=0, status_o=00, counters cleared, abort latch cleared, and cmd_ready_o=1 in the cycle after.
REQ-023 Reset mid-transaction SHALL drop cfg_valid_o immediately with no clear write issued.

Structure
REQ-024 Package udma_eth_frame_pkg SHALL hold the register offsets, CFG bit indices, the state enum and the status enum.
REQ-025 A single sub-module, udma_eth_frame_poll_timer, SHALL implement the gap counter and poll counter with load, tick and expiry outputs.

Verification
REQ-026 RX cmd addr=0x123 size=0x40 cont=0, ready always 1 -> writes 0x00=0x123, 0x01=0x40, 0x02=0x10; first poll returns 0 -> done_o with status 00.
REQ-027 TX cont=1, cfg_ready_i delayed 3 cycles per transfer -> signals held stable during each wait; writes 0x04, 0x05, 0x06=0x11; no reads; status 00.
REQ-028 Polls return 0x30 indefinitely with MAX_POLLS=4 -> exactly 4 reads spaced POLL_GAP apart, then write 0x02=0x40, status 10.
REQ-029 abort_i during WR_SIZE while cfg_ready_i is low -> WR_SIZE completes, then CFG=0x40 write, status 01, no further polls.
REQ-030 rst_i asserted during POLL_RD -> next cycle cfg_valid_o=0 and busy_o=0; a new command is accepted normally.
